alu_sequencer: RTL

- Issues register-to-register instructions to the combinational 16-bit ALU and owns the 16-entry general register file.
- Accepts one instruction at a time over a valid/ready handshake. Reads both operands, drives the ALU `r1`/`r2`/`opcode` inputs, captures `rout`, and writes the result back to the destination register.
- Sits between the instruction source (fetch logic or a testbench) and the ALU instance.

---
 rtl/alu_sequencer_if.sv | 38 +++
 rtl/alu_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Bundle between an instruction source (master) and the alu_sequencer (slave):
// issue handshake, ALU operand/result bus, writeback report, preload and debug read.
interface alu_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_ADDR_W = 4
);
   localparam int INSTR_W = 8 + 2 * REG_ADDR_W;

   logic                  instr_valid;
   logic                  instr_ready;
   logic [INSTR_W-1:0]    instr;
   logic [DATA_WIDTH-1:0] alu_r1;
   logic [DATA_WIDTH-1:0] alu_r2;
   logic [7:0]            alu_opcode;
   logic [DATA_WIDTH-1:0] alu_rout;
   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_addr;
   logic [DATA_WIDTH-1:0] wb_data;
   logic [DATA_WIDTH-1:0] cmp_result;
   logic                  illegal_op;
   logic                  ld_en;
   logic [REG_ADDR_W-1:0] ld_addr;
   logic [DATA_WIDTH-1:0] ld_data;
   logic [REG_ADDR_W-1:0] dbg_addr;
   logic [DATA_WIDTH-1:0] dbg_data;

   modport master (
      output instr_valid, instr, alu_rout, ld_en, ld_addr, ld_data, dbg_addr,
      input  instr_ready, alu_r1, alu_r2, alu_opcode, wb_valid, wb_addr, wb_data,
             cmp_result, illegal_op, dbg_data
   );

   modport slave (
      input  instr_valid, instr, alu_rout, ld_en, ld_addr, ld_data, dbg_addr,
      output instr_ready, alu_r1, alu_r2, alu_opcode, wb_valid, wb_addr, wb_data,
             cmp_result, illegal_op, dbg_data
   );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state issue engine that reads two registers, drives an external combinational
// ALU, and writes the result back into its own general register file.
module alu_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_ADDR_W = 4
) (
   input  logic           clock,
   input  logic           reset,
   alu_sequencer_if.slave bus
);
   localparam int         DEPTH   = 2 ** REG_ADDR_W;
   localparam int         INSTR_W = 8 + 2 * REG_ADDR_W;
   localparam logic [7:0] OP_CMP  = 8'h0B;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   state_t                state_q, state_d;
   logic [INSTR_W-1:0]    instr_q, instr_d;
   logic [DATA_WIDTH-1:0] aluR1_q, aluR1_d;
   logic [DATA_WIDTH-1:0] aluR2_q, aluR2_d;
   logic [7:0]            aluOpcode_q, aluOpcode_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  wbValid_q, wbValid_d;
   logic [REG_ADDR_W-1:0] wbAddr_q, wbAddr_d;
   logic [DATA_WIDTH-1:0] wbData_q, wbData_d;
   logic [DATA_WIDTH-1:0] cmpResult_q, cmpResult_d;
   logic                  illegalOp_q, illegalOp_d;
   logic [DATA_WIDTH-1:0] regFile_q [DEPTH];

   logic                  instrReady;
   logic                  accept;
   logic [7:0]            newOpcode;
   logic [7:0]            opcode;
   logic [REG_ADDR_W-1:0] rdest;
   logic [REG_ADDR_W-1:0] rsrc;
   logic                  isCmp;
   logic                  regWrite;

   function automatic logic isLegal(input logic [7:0] op);
      case (op)
         8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
         8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0E, 8'h0F, 8'h84: isLegal = 1'b1;
         default:                                         isLegal = 1'b0;
      endcase
   endfunction

   assign instrReady = reset && (state_q == IDLE);
   assign accept     = bus.instr_valid && instrReady;
   assign newOpcode  = bus.instr[INSTR_W-1 -: 8];
   assign opcode     = instr_q[INSTR_W-1 -: 8];
   assign rdest      = instr_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
   assign rsrc       = instr_q[REG_ADDR_W-1:0];
   assign isCmp      = (opcode == OP_CMP);
   assign regWrite   = (state_q == WRITE) && !isCmp;

   // Writeback report is registered at the end of EXEC so it is visible throughout WRITE.
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      aluR1_d     = aluR1_q;
      aluR2_d     = aluR2_q;
      aluOpcode_d = aluOpcode_q;
      result_d    = result_q;
      wbValid_d   = 1'b0;
      wbAddr_d    = wbAddr_q;
      wbData_d    = wbData_q;
      cmpResult_d = cmpResult_q;
      illegalOp_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (isLegal(newOpcode)) begin
                  instr_d = bus.instr;
                  state_d = READ;
               end else begin
                  illegalOp_d = 1'b1;
               end
            end
         end
         READ: begin
            aluR1_d     = regFile_q[rdest];
            aluR2_d     = regFile_q[rsrc];
            aluOpcode_d = opcode;
            state_d     = EXEC;
         end
         EXEC: begin
            result_d = bus.alu_rout;
            if (!isCmp) begin
               wbValid_d = 1'b1;
               wbAddr_d  = rdest;
               wbData_d  = bus.alu_rout;
            end
            state_d = WRITE;
         end
         WRITE: begin
            if (isCmp) begin
               cmpResult_d = result_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         instr_q     <= '0;
         aluR1_q     <= '0;
         aluR2_q     <= '0;
         aluOpcode_q <= '0;
         result_q    <= '0;
         wbValid_q   <= 1'b0;
         wbAddr_q    <= '0;
         wbData_q    <= '0;
         cmpResult_q <= '0;
         illegalOp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         aluR1_q     <= aluR1_d;
         aluR2_q     <= aluR2_d;
         aluOpcode_q <= aluOpcode_d;
         result_q    <= result_d;
         wbValid_q   <= wbValid_d;
         wbAddr_q    <= wbAddr_d;
         wbData_q    <= wbData_d;
         cmpResult_q <= cmpResult_d;
         illegalOp_q <= illegalOp_d;
      end
   end

   // The writeback is assigned last so it overrides a preload to the same register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regFile_q[i] <= '0;
         end
      end else begin
         if (bus.ld_en) begin
            regFile_q[bus.ld_addr] <= bus.ld_data;
         end
         if (regWrite) begin
            regFile_q[rdest] <= result_q;
         end
      end
   end

   assign bus.instr_ready = instrReady;
   assign bus.alu_r1      = aluR1_q;
   assign bus.alu_r2      = aluR2_q;
   assign bus.alu_opcode  = aluOpcode_q;
   assign bus.wb_valid    = wbValid_q;
   assign bus.wb_addr     = wbAddr_q;
   assign bus.wb_data     = wbData_q;
   assign bus.cmp_result  = cmpResult_q;
   assign bus.illegal_op  = illegalOp_q;
   assign bus.dbg_data    = regFile_q[bus.dbg_addr];

endmodule
